// File: rtl/sumador_serial.sv
// Bit-serial N-bit adder: one sum bit per clock, LSB first, through a single
// full adder with a registered carry. Three-state control (IDLE/RUN/DONE)
// with back-to-back restart from DONE.
module sumador_serial #(
  parameter int unsigned N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         carry_i,
  output logic [N-1:0] suma_o,
  output logic         carry_o,
  output logic         busy_o,
  output logic         done_o
);

  // Counter must be able to hold N itself without wrapping.
  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    r_state;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_sum;
  logic          r_carry;
  logic [CW-1:0] r_cnt;

  logic          w_bit;
  logic          w_cout;
  logic          w_last;
  logic [N-1:0]  w_sum_next;

  // Full adder on the operand LSBs plus the shifted-in result word.
  always_comb begin
    w_bit      = r_a[0] ^ r_b[0] ^ r_carry;
    w_cout     = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    w_sum_next = {w_bit, r_sum[N-1:1]};
    w_last     = (r_cnt == CW'(N - 1));
  end

  // Control and datapath; outputs are only updated on entry to DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      suma_o  <= '0;
      carry_o <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start_i) begin
            r_a     <= a_i;
            r_b     <= b_i;
            r_carry <= carry_i;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_sum   <= w_sum_next;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= DONE;
            suma_o  <= w_sum_next;
            carry_o <= w_cout;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy_o = (r_state == RUN);
  assign done_o = (r_state == DONE);

endmodule
